// File: rtl/stim_pattern_gen.sv
// Parametrised address/data burst generator with valid/ready handshake.
// Optional inter-beat gap: define STIM_PATTERN_GEN_GAP_EN to add gap_cycles.
module stim_pattern_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned ADDR_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  burst_len,
`ifdef STIM_PATTERN_GEN_GAP_EN
  input  logic [7:0]            gap_cycles,
`endif
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_WALK1 = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic                  abort_q, abort_d;
  logic                  done_q, done_d;
`ifdef STIM_PATTERN_GEN_GAP_EN
  logic [7:0]            gap_q, gap_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
`endif

  logic xfer;
  logic is_last;

  // Data of the beat following d under pattern m.
  function automatic logic [DATA_WIDTH-1:0] next_data(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [1:0]            m);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      MODE_INC:   r = d + DATA_ONE;
      MODE_FIXED: r = d;
      // A zero seed would rotate to zero forever, so restart the walk at bit 0.
      MODE_WALK1: r = (d == '0) ? DATA_ONE : {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
      default:    r = ~d;
    endcase
    return r;
  endfunction

  assign xfer    = valid_q && ready_in;
  // len_q of zero wraps to all-ones, giving a 2^LEN_WIDTH beat burst.
  assign is_last = (cnt_q == (len_q - LEN_ONE));

  // Next-state and beat-update logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    abort_d = abort_q;
    done_d  = 1'b0;
`ifdef STIM_PATTERN_GEN_GAP_EN
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          addr_d  = base_addr;
          data_d  = seed;
          cnt_d   = '0;
          len_d   = burst_len;
          mode_d  = mode;
          abort_d = 1'b0;
`ifdef STIM_PATTERN_GEN_GAP_EN
          gap_d     = gap_cycles;
          gap_cnt_d = 8'd0;
`endif
        end
      end
      ST_RUN: begin
        if (stop) abort_d = 1'b1;
        if (xfer) begin
          if (is_last) begin
            // Completion takes priority over a coincident abort.
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else if (abort_q || stop) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            abort_d = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_INC;
            data_d = next_data(data_q, mode_q);
            cnt_d  = cnt_q + LEN_ONE;
`ifdef STIM_PATTERN_GEN_GAP_EN
            if (gap_q != 8'd0) begin
              valid_d   = 1'b0;
              gap_cnt_d = gap_q;
            end
`endif
          end
        end
`ifdef STIM_PATTERN_GEN_GAP_EN
        else if (!valid_q) begin
          // Counting down an inter-beat gap; an abort ends the burst here.
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_d = 8'd0;
            if (abort_q || stop) begin
              state_d = ST_IDLE;
              abort_d = 1'b0;
            end else begin
              valid_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and beat registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_INC;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef STIM_PATTERN_GEN_GAP_EN
      gap_q     <= 8'd0;
      gap_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      abort_q <= abort_d;
      done_q  <= done_d;
`ifdef STIM_PATTERN_GEN_GAP_EN
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign valid_out = valid_q;
  assign addr_out  = addr_q;
  assign data_out  = data_q;
  assign last_out  = valid_q && is_last;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen with a beat scoreboard.
module tb_stim_pattern_gen;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        start, stop;
  logic [1:0]  mode;
  logic [7:0]  base_addr;
  logic [31:0] seed;
  logic [3:0]  burst_len;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  addr_out;
  logic [31:0] data_out;
  logic        last_out, busy, done;
`ifdef STIM_PATTERN_GEN_GAP_EN
  logic [7:0]  gap_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  stim_pattern_gen #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(4), .ADDR_STEP(1)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop), .mode(mode),
    .base_addr(base_addr), .seed(seed), .burst_len(burst_len),
`ifdef STIM_PATTERN_GEN_GAP_EN
    .gap_cycles(gap_cycles),
`endif
    .ready_in(ready_in), .valid_out(valid_out), .addr_out(addr_out),
    .data_out(data_out), .last_out(last_out), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one burst, derived from the pattern definitions.
  task automatic push_model(input logic [7:0] base, input logic [31:0] sd,
                            input logic [1:0] md, input logic [3:0] len);
    int nb;
    beat_t b;
    logic [7:0] a;
    logic [31:0] d;
    nb = (len == 4'd0) ? 16 : int'(len);
    a = base;
    d = sd;
    for (int i = 0; i < nb; i++) begin
      b.a = a; b.d = d; b.l = (i == nb - 1);
      sb.push_back(b);
      a = a + 8'd1;
      case (md)
        2'd0: d = d + 32'd1;
        2'd1: d = d;
        2'd2: d = (d == 32'd0) ? 32'd1 : {d[30:0], d[31]};
        default: d = ~d;
      endcase
    end
  endtask

  // Compare the presented beat to the head of the scoreboard.
  task automatic check_beat(input string tag);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      check({tag, "_addr"}, 64'(addr_out), 64'(sb[0].a));
      check({tag, "_data"}, 64'(data_out), 64'(sb[0].d));
      check({tag, "_last"}, 64'(last_out), 64'(sb[0].l));
    end
  endtask

  task automatic issue_start(input logic [7:0] base, input logic [31:0] sd,
                             input logic [1:0] md, input logic [3:0] len);
    base_addr = base; seed = sd; mode = md; burst_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full burst; rpat 0 = ready held high, 1 = ready pattern 1,0,0 repeating.
  task automatic run_burst(input string tag, input logic [7:0] base, input logic [31:0] sd,
                           input logic [1:0] md, input logic [3:0] len, input int rpat,
                           input bit start_in_done);
    int nb, xfers, cyc;
    bit fin;
    nb = (len == 4'd0) ? 16 : int'(len);
    push_model(base, sd, md, len);
    issue_start(base, sd, md, len);
    check({tag, "_latency_valid"}, 64'(valid_out), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    xfers = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      ready_in = (rpat == 0) ? 1'b1 : ((cyc % 3) == 0);
      check({tag, "_valid_held"}, 64'(valid_out), 64'd1);
      check_beat(tag);
      if (valid_out && ready_in) begin
        if (sb.size() != 0) void'(sb.pop_front());
        xfers++;
        if (xfers == nb) fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_finished"}, 64'(fin), 64'd1);
    $display("[TB] %s: %0d transfers in %0d cycles", tag, xfers, cyc);
    check({tag, "_end_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_end_busy"}, 64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_once"}, 64'(done), 64'd0);
    check({tag, "_idle_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    sb.delete();
  endtask

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    base_addr = 8'h0; seed = 32'h0; burst_len = 4'd0; ready_in = 1'b1;
`ifdef STIM_PATTERN_GEN_GAP_EN
    gap_cycles = 8'd0;
`endif
    #12;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_last", 64'(last_out), 64'd0);
    check("rst_addr", 64'(addr_out), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst("inc4", 8'h10, 32'h0, 2'd0, 4'd4, 0, 1'b1);
    run_burst("inc4_stall", 8'h10, 32'h0, 2'd0, 4'd4, 1, 1'b0);
    run_burst("walk1_wrap", 8'hFE, 32'h8000_0000, 2'd2, 4'd3, 0, 1'b0);
    run_burst("toggle16", 8'h20, 32'hA5A5_A5A5, 2'd3, 4'd0, 0, 1'b0);
    run_burst("walk1_zero", 8'h40, 32'h0, 2'd2, 4'd4, 1, 1'b0);
    run_burst("fixed2", 8'h50, 32'h1234_5678, 2'd1, 4'd2, 0, 1'b0);
    run_burst("len1", 8'h58, 32'h7, 2'd0, 4'd1, 0, 1'b0);

    // start and stop together in IDLE: stop wins.
    base_addr = 8'h30; seed = 32'h1; mode = 2'd0; burst_len = 4'd2;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("startstop_valid", 64'(valid_out), 64'd0);
    check("startstop_busy", 64'(busy), 64'd0);
    $display("[TB] start+stop in IDLE: valid=%0b busy=%0b", valid_out, busy);

    // Abort: stop while beat 3 is stalled, beat 3 still completes.
    ready_in = 1'b1;
    push_model(8'h60, 32'h100, 2'd0, 4'd10);
    issue_start(8'h60, 32'h100, 2'd0, 4'd10);
    for (int i = 0; i < 3; i++) begin
      check_beat("abort_pre");
      void'(sb.pop_front());
      @(posedge clk); #1;
    end
    ready_in = 1'b0; stop = 1'b1;
    check_beat("abort_b3");
    @(posedge clk); #1;
    stop = 1'b0;
    check("abort_hold_valid", 64'(valid_out), 64'd1);
    check_beat("abort_hold");
    @(posedge clk); #1;
    check_beat("abort_hold2");
    ready_in = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 64'(valid_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("abort_done_after", 64'(done), 64'd0);
    check("abort_idle_valid", 64'(valid_out), 64'd0);
    $display("[TB] abort: valid=%0b busy=%0b done=%0b", valid_out, busy, done);
    sb.delete();

    // stop coincident with the final transfer: completion wins.
    push_model(8'h70, 32'h9, 2'd0, 4'd2);
    issue_start(8'h70, 32'h9, 2'd0, 4'd2);
    check_beat("stoplast_b0");
    void'(sb.pop_front());
    @(posedge clk); #1;
    stop = 1'b1;
    check_beat("stoplast_b1");
    @(posedge clk); #1;
    stop = 1'b0;
    check("stoplast_done", 64'(done), 64'd1);
    check("stoplast_valid", 64'(valid_out), 64'd0);
    $display("[TB] stop on final beat: done=%0b", done);
    @(posedge clk); #1;
    sb.delete();

    // Asynchronous reset mid-burst.
    issue_start(8'h80, 32'hDEAD_BEEF, 2'd0, 4'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_addr", 64'(addr_out), 64'd0);
    check("midrst_data", 64'(data_out), 64'd0);
    check("midrst_last", 64'(last_out), 64'd0);
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_after_valid", 64'(valid_out), 64'd0);
    check("midrst_after_done", 64'(done), 64'd0);
    $display("[TB] reset mid-burst: valid=%0b busy=%0b done=%0b", valid_out, busy, done);

`ifdef STIM_PATTERN_GEN_GAP_EN
    // Gap of 2 cycles between beats: valid 1,0,0,1,0,0,1 then done.
    begin
      logic [6:0] vexp;
      vexp = 7'b1001001;
      gap_cycles = 8'd2;
      ready_in = 1'b1;
      push_model(8'h90, 32'h0, 2'd0, 4'd3);
      issue_start(8'h90, 32'h0, 2'd0, 4'd3);
      for (int i = 0; i < 7; i++) begin
        check("gap_valid", 64'(valid_out), 64'(vexp[6 - i]));
        if (valid_out) begin
          check_beat("gap");
          if (sb.size() != 0) void'(sb.pop_front());
        end
        @(posedge clk); #1;
      end
      check("gap_done", 64'(done), 64'd1);
      $display("[TB] gap burst: done=%0b", done);
      gap_cycles = 8'd0;
      @(posedge clk); #1;
      sb.delete();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
